pipe_ctrl: RTL and testbench

- Central pipeline control unit for the five-stage MIPS core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sequences exception/ERET flushes: drives flush and new_pc, and holds flush for a programmable number of cycles.
- Keeps a saturating stall-cycle counter and a sticky stall-timeout flag for debug.

---
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: stall vector merge, exception/ERET
// flush sequencing, and stall-cycle debug counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE    = 32'h0000_000e,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  // state    | meaning
  // ST_RUN   | normal issue; an exception flushes combinationally this cycle
  // ST_FLUSH | remaining flush cycles, redirect to latched target
  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(TIMEOUT);

  state_t          r_state;
  logic [CW-1:0]   r_flush_cnt;
  logic [31:0]     r_target;
  logic [RW-1:0]   r_run_len;

  logic            w_exc;
  logic [31:0]     w_exc_target;
  logic [5:0]      w_stall_req;
  logic [RW-1:0]   w_run_len_nxt;

  assign w_exc        = (excepttype_i != 32'h0);
  assign w_exc_target = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

  always_comb begin
    w_stall_req = 6'b000000;
    if (stallreq_from_mem)     w_stall_req = 6'b011111;
    else if (stallreq_from_ex) w_stall_req = 6'b001111;
    else if (stallreq_from_id) w_stall_req = 6'b000111;
    else if (stallreq_from_if) w_stall_req = 6'b000011;
  end

  // Outputs are forced to zero while reset is held, so a mid-flush reset
  // drops flush/new_pc immediately regardless of the input pins.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst) begin
      if (r_state == ST_FLUSH) begin
        flush  = 1'b1;
        new_pc = r_target;
      end else if (w_exc) begin
        flush  = 1'b1;
        new_pc = w_exc_target;
      end else begin
        stall  = w_stall_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_target    <= 32'h0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_exc) begin
            r_target <= w_exc_target;
            if (FLUSH_CYCLES > 1) begin
              r_state     <= ST_FLUSH;
              r_flush_cnt <= CNT_INIT;
            end
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt > CW'(1)) begin
            r_flush_cnt <= r_flush_cnt - CW'(1);
          end else begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    if (stall == 6'b000000 || flush) w_run_len_nxt = '0;
    else if (r_run_len == RUN_MAX)   w_run_len_nxt = RUN_MAX;
    else                             w_run_len_nxt = r_run_len + RW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= 32'h0;
      stall_timeout <= 1'b0;
      r_run_len     <= '0;
    end else begin
      if (stall != 6'b000000 && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      r_run_len <= w_run_len_nxt;
      if (w_run_len_nxt == RUN_MAX)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic checked against
// a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int          FLUSH_N = 2;
  localparam int          TO_N    = 8;
  localparam logic [31:0] EXC_VEC = 32'h0000_0020;
  localparam logic [31:0] ERET    = 32'h0000_000e;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_flush_left;
  logic [31:0] m_target;
  longint      m_stall_cnt;
  int          m_run;
  bit          m_to;

  pipe_ctrl #(
    .EXC_VECTOR(EXC_VEC), .ERET_CODE(ERET),
    .FLUSH_CYCLES(FLUSH_N), .TIMEOUT(TO_N)
  ) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(req_if), .stallreq_from_id(req_id),
    .stallreq_from_ex(req_ex), .stallreq_from_mem(req_mem),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_target     = 32'h0;
    m_stall_cnt  = 0;
    m_run        = 0;
    m_to         = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, {26'h0, stall}, 32'h0);
    chk({tag, "_flush"}, {31'h0, flush}, 32'h0);
    chk({tag, "_new_pc"}, new_pc, 32'h0);
    chk({tag, "_stall_cycles"}, stall_cycles, 32'h0);
    chk({tag, "_timeout"}, {31'h0, stall_timeout}, 32'h0);
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance.
  task automatic step(input string tag, input logic [3:0] req,
                      input logic [31:0] e, input logic [31:0] pc_in);
    logic [5:0]  x_stall;
    logic        x_flush;
    logic [31:0] x_pc;
    {req_mem, req_ex, req_id, req_if} = req;
    exc = e;
    epc = pc_in;
    #1;
    x_stall = 6'd0;
    x_flush = 1'b0;
    x_pc    = 32'h0;
    if (m_flush_left > 0) begin
      x_flush = 1'b1;
      x_pc    = m_target;
    end else if (e != 32'h0) begin
      x_flush = 1'b1;
      x_pc    = (e == ERET) ? pc_in : EXC_VEC;
    end else if (req[3]) x_stall = 6'd31;
    else if (req[2])     x_stall = 6'd15;
    else if (req[1])     x_stall = 6'd7;
    else if (req[0])     x_stall = 6'd3;
    chk({tag, "_stall"}, {26'h0, stall}, {26'h0, x_stall});
    chk({tag, "_flush"}, {31'h0, flush}, {31'h0, x_flush});
    chk({tag, "_new_pc"}, new_pc, x_pc);
    chk({tag, "_stall_cycles"}, stall_cycles, m_stall_cnt[31:0]);
    chk({tag, "_timeout"}, {31'h0, stall_timeout}, {31'h0, m_to});
    @(posedge clk);
    if (m_flush_left > 0) m_flush_left--;
    else if (e != 32'h0) begin
      m_target     = x_pc;
      m_flush_left = FLUSH_N - 1;
    end
    if (x_stall != 0 && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
    if (x_stall != 0 && !x_flush) m_run = (m_run < TO_N) ? m_run + 1 : TO_N;
    else m_run = 0;
    if (m_run >= TO_N) m_to = 1'b1;
    #1;
  endtask

  task automatic rand_steps(input int n);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = 32'h0;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       e = ERET;
          1:       e = 32'h0000_0008;
          default: e = $urandom | 32'h1;
        endcase
      end
      step("rand", 4'($urandom_range(0, 15) & ($urandom_range(0, 3) == 0 ? 0 : 15)),
           e, $urandom);
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    {req_mem, req_ex, req_id, req_if} = 4'($urandom);
    exc = $urandom | 32'h1;
    epc = $urandom;
    #3;
    check_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    step("idle", 4'b0000, 0, 0);
    step("idle", 4'b0000, 0, 0);

    // priority
    step("prio_id",  4'b0010, 0, 0);
    step("prio_ex",  4'b0110, 0, 0);
    step("prio_mem", 4'b1110, 0, 0);
    step("prio_if",  4'b0001, 0, 0);
    step("idle", 4'b0000, 0, 0);

    // exception while EX stalls
    step("exc", 4'b0100, 32'h8, 32'h5555_0000);
    step("exc_fl", 4'b0100, 0, 0);
    step("exc_post", 4'b0100, 0, 0);
    step("idle", 4'b0000, 0, 0);

    // ERET, then a second exception during the flush cycle is dropped
    step("eret", 4'b0000, ERET, 32'h0000_1234);
    step("eret_fl", 4'b1000, 32'h8, 32'hDEAD_BEEF);
    step("eret_post", 4'b0000, 0, 0);

    // timeout: 7 stalled, 1 gap, 8 stalled, then drop
    for (int i = 0; i < 7; i++) step("to_a", 4'b0010, 0, 0);
    step("to_gap", 4'b0000, 0, 0);
    for (int i = 0; i < 8; i++) step("to_b", 4'b0010, 0, 0);
    for (int i = 0; i < 3; i++) step("to_hold", 4'b0000, 0, 0);

    rand_steps(300);

    // reset in the second flush cycle
    step("mr_exc", 4'b0000, 32'h8, 0);
    {req_mem, req_ex, req_id, req_if} = 4'b0100;
    exc = 32'h8;
    #1;
    chk("mr_pre_flush", {31'h0, flush}, 32'h1);
    rst = 1'b0;
    #1;
    model_reset();
    check_zero("mr_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    step("mr_run", 4'b0010, 0, 0);
    step("mr_exc2", 4'b0000, 32'h4, 0);
    step("mr_fl2", 4'b0000, 0, 0);
    step("mr_post", 4'b0001, 0, 0);

    rand_steps(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
